// File: rtl/branch_cond_controller_pkg.sv
// Shared definitions for branch resolution: condition codes, flag bit
// positions within {N,Z,C,V}, and the controller state encoding.
package branch_cond_controller_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FLAGS,
    ST_RESOLVE,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/branch_cond_controller_cond_evaluator.sv
// Combinational condition-code test: selects one of 16 predicates over
// the {N,Z,C,V} flags and reports whether the branch is taken.
module cond_evaluator
  import branch_cond_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_controller.sv
// Conditional-branch sequencer: waits for in-flight flag writers, resolves
// the condition against the flag register and holds flush after a taken branch.
module branch_cond_controller
  import branch_cond_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] flags_in,
  input  logic       flags_we,
  input  logic       flag_pending,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  output logic       br_ready,
  output logic       br_done,
  output logic       br_taken,
  output logic       stall,
  output logic       flush,
  output logic [3:0] flags_q
);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               HAS_FLUSH = (FLUSH_CYCLES > 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cond_q;
  logic             taken;

  cond_evaluator u_cond_evaluator (
    .cond  (cond_q),
    .flags (flags_q),
    .taken (taken)
  );

  // Flag register tracks the ALU regardless of where the FSM is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= '0;
    else if (flags_we) flags_q <= flags_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cond_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && br_valid) cond_q <= br_cond;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (br_valid) state_nxt = (flag_pending || flags_we) ? ST_WAIT_FLAGS : ST_RESOLVE;
      end
      ST_WAIT_FLAGS: begin
        if (!flag_pending && !flags_we) state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (taken && HAS_FLUSH) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign br_ready = (state == ST_IDLE);
  assign stall    = (state != ST_IDLE);
  assign br_done  = (state == ST_RESOLVE);
  assign br_taken = (state == ST_RESOLVE) && taken;
  assign flush    = (state == ST_FLUSH);

endmodule

// File: tb/tb_branch_cond_controller.sv
// Directed bench for branch_cond_controller: default flush build plus a
// zero-flush build sharing the same stimulus.
module tb_branch_cond_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] flags_in = '0;
  logic       flags_we = 1'b0;
  logic       flag_pending = 1'b0;
  logic       br_valid = 1'b0;
  logic [3:0] br_cond = '0;

  logic       br_ready, br_done, br_taken, stall, flush;
  logic [3:0] flags_q;
  logic       z_br_ready, z_br_done, z_br_taken, z_stall, z_flush;
  logic [3:0] z_flags_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_cond_controller #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .flags_we(flags_we),
    .flag_pending(flag_pending), .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(br_ready), .br_done(br_done), .br_taken(br_taken),
    .stall(stall), .flush(flush), .flags_q(flags_q)
  );

  branch_cond_controller #(.FLUSH_CYCLES(0), .CNT_W(2)) dut_z (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .flags_we(flags_we),
    .flag_pending(flag_pending), .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(z_br_ready), .br_done(z_br_done), .br_taken(z_br_taken),
    .stall(z_stall), .flush(z_flush), .flags_q(z_flags_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    r = 1'b0;
    case (c)
      4'd0:  r = (z == 1'b1);
      4'd1:  r = (z == 1'b0);
      4'd2:  r = (cy == 1'b1);
      4'd3:  r = (cy == 1'b0);
      4'd4:  r = (n == 1'b1);
      4'd5:  r = (n == 1'b0);
      4'd6:  r = (v == 1'b1);
      4'd7:  r = (v == 1'b0);
      4'd8:  r = (cy == 1'b1) && (z == 1'b0);
      4'd9:  r = !((cy == 1'b1) && (z == 1'b0));
      4'd10: r = ((n ^ v) == 1'b0);
      4'd11: r = ((n ^ v) == 1'b1);
      4'd12: r = (z == 1'b0) && ((n ^ v) == 1'b0);
      4'd13: r = !((z == 1'b0) && ((n ^ v) == 1'b0));
      4'd14: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Issues one request from an IDLE slot and observes it until br_ready returns.
  task automatic run_branch(input logic [3:0] cond, output int dones, output int done_at,
                            output logic taken, output int flushes, output int ready_at,
                            output logic tmo);
    br_cond = cond;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    dones = 0; done_at = -1; taken = 1'b0; flushes = 0; ready_at = -1; tmo = 1'b1;
    for (int c = 1; c < 40; c++) begin
      if (br_done) begin dones++; done_at = c; taken = br_taken; end
      if (flush) flushes++;
      if (br_ready) begin ready_at = c; tmo = 1'b0; break; end
      tick();
    end
  endtask

  task automatic write_flags(input logic [3:0] f);
    flags_in = f;
    flags_we = 1'b1;
    tick();
    flags_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_cmp++;
    if ({br_ready, br_done, br_taken, stall, flush, flags_q} !== {5'b10000, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b",
               {br_ready, br_done, br_taken, stall, flush, flags_q}, 9'b100000000);
    end
    n_cmp++;
    if ({z_br_ready, z_br_done, z_flush, z_flags_q} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_outputs_z: got %b expected %b",
               {z_br_ready, z_br_done, z_flush, z_flags_q}, 7'b1000000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_eq_latency();
    int dones, done_at, flushes, ready_at;
    logic taken, tmo;
    write_flags(4'b0100);
    n_cmp++;
    if (flags_q !== 4'b0100) begin
      n_err++; $display("FAIL eq_flags_q: got %b expected %b", flags_q, 4'b0100);
    end
    run_branch(4'd0, dones, done_at, taken, flushes, ready_at, tmo);
    n_cmp++;
    if (done_at !== 1 || dones !== 1) begin
      n_err++; $display("FAIL eq_done: got at=%0d n=%0d expected at=1 n=1", done_at, dones);
    end
    n_cmp++;
    if (taken !== 1'b1) begin n_err++; $display("FAIL eq_taken: got %b expected 1", taken); end
    n_cmp++;
    if (flushes !== 2) begin n_err++; $display("FAIL eq_flush_len: got %0d expected 2", flushes); end
    n_cmp++;
    if (ready_at !== 4 || tmo !== 1'b0) begin
      n_err++; $display("FAIL eq_ready_at: got %0d expected 4", ready_at);
    end
  endtask

  task automatic test_ne_nv_back_to_back();
    int dones, done_at, flushes, ready_at;
    logic taken, tmo;
    write_flags(4'b0000);
    run_branch(4'd1, dones, done_at, taken, flushes, ready_at, tmo);
    n_cmp++;
    if (taken !== 1'b1 || dones !== 1) begin
      n_err++; $display("FAIL ne_taken: got taken=%b n=%0d expected taken=1 n=1", taken, dones);
    end
    n_cmp++;
    if (flushes !== 2 || ready_at !== 4) begin
      n_err++; $display("FAIL ne_flush: got flush=%0d ready=%0d expected flush=2 ready=4", flushes, ready_at);
    end
    run_branch(4'd15, dones, done_at, taken, flushes, ready_at, tmo);
    n_cmp++;
    if (taken !== 1'b0 || dones !== 1 || done_at !== 1) begin
      n_err++; $display("FAIL nv_taken: got taken=%b n=%0d at=%0d expected taken=0 n=1 at=1", taken, dones, done_at);
    end
    n_cmp++;
    if (flushes !== 0 || ready_at !== 2) begin
      n_err++; $display("FAIL nv_idle: got flush=%0d ready=%0d expected flush=0 ready=2", flushes, ready_at);
    end
  endtask

  task automatic test_pending_wait();
    int dones;
    write_flags(4'b1000);
    br_cond = 4'd10;
    br_valid = 1'b1;
    flag_pending = 1'b1;
    tick();
    br_valid = 1'b0;
    dones = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin flag_pending = 1'b0; flags_in = 4'b1001; flags_we = 1'b1; end
      if (c == 4) flags_we = 1'b0;
      n_cmp++;
      if (stall !== 1'b1 || br_ready !== 1'b0) begin
        n_err++; $display("FAIL pend_stall_c%0d: got stall=%b ready=%b expected 1 0", c, stall, br_ready);
      end
      if (br_done) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0) begin n_err++; $display("FAIL pend_early_done: got %0d expected 0", dones); end
    n_cmp++;
    if (br_done !== 1'b1 || br_taken !== 1'b1) begin
      n_err++; $display("FAIL pend_ge_resolve: got done=%b taken=%b expected 1 1", br_done, br_taken);
    end
    for (int c = 0; c < 10 && !br_ready; c++) tick();
    n_cmp++;
    if (br_ready !== 1'b1) begin n_err++; $display("FAIL pend_return: got ready=%b expected 1", br_ready); end
  endtask

  task automatic test_sweep();
    int dones, done_at, flushes, ready_at;
    logic taken, tmo, exp;
    for (int f = 0; f < 16; f++) begin
      write_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        exp = model_taken(4'(c), 4'(f));
        run_branch(4'(c), dones, done_at, taken, flushes, ready_at, tmo);
        n_cmp++;
        if (taken !== exp || tmo !== 1'b0) begin
          n_err++; $display("FAIL sweep_taken c=%0d f=%b: got %b expected %b", c, 4'(f), taken, exp);
        end
        n_cmp++;
        if (dones !== 1) begin
          n_err++; $display("FAIL sweep_done_count c=%0d f=%b: got %0d expected 1", c, 4'(f), dones);
        end
        n_cmp++;
        if (flushes !== (exp ? 2 : 0)) begin
          n_err++; $display("FAIL sweep_flush c=%0d f=%b: got %0d expected %0d", c, 4'(f), flushes, exp ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_reset_in_flush();
    int dones, flushes;
    write_flags(4'b1111);
    br_cond = 4'd14;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (flush !== 1'b1) begin n_err++; $display("FAIL rst_pre_flush: got %b expected 1", flush); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({flush, stall, br_ready, br_done, flags_q} !== 8'b00100000) begin
      n_err++; $display("FAIL rst_async: got %b expected %b", {flush, stall, br_ready, br_done, flags_q}, 8'b00100000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0; flushes = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (br_done) dones++;
      if (flush) flushes++;
    end
    n_cmp++;
    if (dones !== 0 || flushes !== 0) begin
      n_err++; $display("FAIL rst_after_release: got done=%0d flush=%0d expected 0 0", dones, flushes);
    end
  endtask

  task automatic test_zero_flush();
    int zf;
    zf = 0;
    reset_n = 1'b0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    br_cond = 4'd14;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    if (z_flush) zf++;
    n_cmp++;
    if (z_br_done !== 1'b1 || z_br_taken !== 1'b1) begin
      n_err++; $display("FAIL zero_done: got done=%b taken=%b expected 1 1", z_br_done, z_br_taken);
    end
    tick();
    if (z_flush) zf++;
    n_cmp++;
    if (z_br_ready !== 1'b1 || z_stall !== 1'b0) begin
      n_err++; $display("FAIL zero_ready: got ready=%b stall=%b expected 1 0", z_br_ready, z_stall);
    end
    for (int c = 0; c < 4; c++) begin tick(); if (z_flush) zf++; end
    n_cmp++;
    if (zf !== 0) begin n_err++; $display("FAIL zero_no_flush: got %0d expected 0", zf); end
  endtask

  initial begin
    test_reset();
    test_eq_latency();
    test_ne_nv_back_to_back();
    test_pending_wait();
    test_sweep();
    test_reset_in_flush();
    test_zero_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
